// File: rtl/scariv_pkg.sv
// ----------------------------------------------------------------------------
// scariv_pkg
//   Shared types and default sizing for the dispatch credit controller.
//   - DISP_* localparams : default sizing used by scariv_disp_credit_ctrl
//   - rsrc_class_t       : resource class ordering (slot k of the packed
//                          per-class vectors)
//   - resource_cnt_t     : packed per-class counter vector
//   - brtag_cnt_t        : branch-tag pool counter
//   - disp_credit_state_t: dispatch controller state (RUN / DRAIN)
// ----------------------------------------------------------------------------
package scariv_pkg;

    localparam int DISP_NUM_RSRC  = 4;
    localparam int DISP_CREDIT_MAX = 16;
    localparam int DISP_BRTAG_MAX  = 8;
    localparam int DISP_CNT_W      = $clog2(DISP_CREDIT_MAX + 1);
    localparam int DISP_BRTAG_W    = $clog2(DISP_BRTAG_MAX + 1);
    localparam int DISP_FLUSH_LAT  = 3;

    // Order matters: class k occupies bits [k*CNT_W +: CNT_W] of every
    // per-class vector on the controller ports.
    typedef enum logic [1:0] {
        RSRC_ALU = 2'd0,
        RSRC_LSU = 2'd1,
        RSRC_BRU = 2'd2,
        RSRC_CSU = 2'd3
    } rsrc_class_t;

    typedef logic [DISP_NUM_RSRC-1:0][DISP_CNT_W-1:0] resource_cnt_t;
    typedef logic [DISP_BRTAG_W-1:0]                  brtag_cnt_t;

    typedef enum logic {
        DISP_RUN   = 1'b0,
        DISP_DRAIN = 1'b1
    } disp_credit_state_t;

endpackage

// File: rtl/scariv_credit_counter.sv
// ----------------------------------------------------------------------------
// scariv_credit_counter
//   One free-entry credit counter. Each cycle the counter takes
//   cnt - consume + return (computed one bit wider than the counter), clamps
//   results above MAX to MAX and results below zero to zero, and raises a
//   sticky error on either event. A reload forces the count back to MAX and
//   leaves the error flag untouched.
//
//   Ports:
//     i_clk, i_reset_n : clock, asynchronous active-low reset (count -> MAX)
//     i_consume        : credits taken this cycle (already gated by dispatch)
//     i_return         : credits freed this cycle (already gated by state)
//     i_reload         : restore count to MAX
//     o_cnt            : current registered credit count
//     o_err            : sticky over-return / underflow flag
// ----------------------------------------------------------------------------
module scariv_credit_counter #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic [W-1:0] i_consume,
    input  logic [W-1:0] i_return,
    input  logic         i_reload,
    output logic [W-1:0] o_cnt,
    output logic         o_err
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;
    logic         err_reg;
    logic         err_next;
    logic [W:0]   gained;
    logic [W:0]   result;

    always_comb begin
        gained   = {1'b0, cnt_reg} + {1'b0, i_return};
        result   = gained - {1'b0, i_consume};
        cnt_next = cnt_reg;
        err_next = err_reg;
        if (i_reload) begin
            cnt_next = W'(MAX);
        end else if (gained < {1'b0, i_consume}) begin
            // Underflow cannot happen while dispatch is gated by ready, but
            // guard it so a wrapped count never masquerades as free credit.
            cnt_next = '0;
            err_next = 1'b1;
        end else if (result > (W+1)'(MAX)) begin
            cnt_next = W'(MAX);
            err_next = 1'b1;
        end else begin
            cnt_next = result[W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_reg <= W'(MAX);
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    assign o_cnt = cnt_reg;
    assign o_err = err_reg;

endmodule

// File: rtl/scariv_disp_credit_ctrl.sv
// ----------------------------------------------------------------------------
// scariv_disp_credit_ctrl
//   Credit-based dispatch gate between rename/dispatch and the issue queues.
//   Keeps one free-entry counter per resource class plus a branch-tag pool and
//   accepts a dispatch group only when every class request and (if needed) a
//   branch tag fit in the registered credits. A flush blocks dispatch for a
//   fixed drain period, after which all credits are reloaded to maximum.
//
//   Ports:
//     i_clk, i_reset_n      : clock, asynchronous active-low reset
//     i_disp_valid          : dispatch group valid
//     i_disp_rsrc_cnt       : requested entries, class k at [k*CNT_W +: CNT_W]
//     i_disp_is_br_included : group needs one branch tag
//     o_disp_ready          : combinational accept (independent of valid)
//     i_ret_valid/i_ret_cnt : per-class credit return strobe / amount
//     i_brtag_ret           : one branch tag freed
//     i_flush               : pipeline flush from commit
//     o_credit              : current free credits per class
//     o_stall_cause         : [k] class k short, [NUM_RSRC] brtag short,
//                             [NUM_RSRC+1] flushing/draining
//     o_credit_err          : sticky over-return / underflow error
//     o_stall_cycles        : per stall-cause saturating 32-bit counters,
//                             present only with SCARIV_DISP_CREDIT_PERF_EN
//
//   Build option: define SCARIV_DISP_CREDIT_PERF_EN to add o_stall_cycles.
// ----------------------------------------------------------------------------
module scariv_disp_credit_ctrl
    import scariv_pkg::*;
#(
    parameter int NUM_RSRC   = DISP_NUM_RSRC,
    parameter int CREDIT_MAX = DISP_CREDIT_MAX,
    parameter int BRTAG_MAX  = DISP_BRTAG_MAX,
    parameter int CNT_W      = $clog2(CREDIT_MAX + 1),
    parameter int FLUSH_LAT  = DISP_FLUSH_LAT
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_disp_valid,
    input  logic [NUM_RSRC*CNT_W-1:0] i_disp_rsrc_cnt,
    input  logic                      i_disp_is_br_included,
    output logic                      o_disp_ready,
    input  logic [NUM_RSRC-1:0]       i_ret_valid,
    input  logic [NUM_RSRC*CNT_W-1:0] i_ret_cnt,
    input  logic                      i_brtag_ret,
    input  logic                      i_flush,
    output logic [NUM_RSRC*CNT_W-1:0] o_credit,
    output logic [NUM_RSRC+1:0]       o_stall_cause,
    output logic                      o_credit_err
`ifdef SCARIV_DISP_CREDIT_PERF_EN
    ,
    output logic [(NUM_RSRC+2)*32-1:0] o_stall_cycles
`endif
);

    localparam int BRTAG_W = $clog2(BRTAG_MAX + 1);
    localparam int DRAIN_W = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;

    disp_credit_state_t state_reg;
    disp_credit_state_t state_next;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic [DRAIN_W-1:0] drain_cnt_next;

    logic [NUM_RSRC-1:0] credit_ok;
    logic [NUM_RSRC-1:0] credit_err;
    logic [BRTAG_W-1:0]  brtag_cnt;
    logic                brtag_err;
    logic                brtag_ok;
    logic                blocked;
    logic                fire;
    logic                reload;
    logic                ret_en;

    // ------------------------------------------------------------------
    // Run/drain sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            DISP_RUN: begin
                if (i_flush) begin
                    state_next     = DISP_DRAIN;
                    drain_cnt_next = DRAIN_W'(FLUSH_LAT - 1);
                end
            end
            DISP_DRAIN: begin
                if (i_flush) begin
                    drain_cnt_next = DRAIN_W'(FLUSH_LAT - 1);
                end else if (drain_cnt_reg == '0) begin
                    state_next = DISP_RUN;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next     = DISP_RUN;
                drain_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= DISP_RUN;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // Reload happens on the last drain cycle so credits are full on the first
    // RUN cycle. Returns arriving while draining are superseded by the reload.
    assign reload  = (state_reg == DISP_DRAIN) && (drain_cnt_reg == '0) && !i_flush;
    assign ret_en  = (state_reg == DISP_RUN);
    assign blocked = (state_reg == DISP_DRAIN) || i_flush;

    // ------------------------------------------------------------------
    // Per-class credit counters
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RSRC; gi++) begin : g_class
            logic [CNT_W-1:0] req;
            logic [CNT_W-1:0] credit;

            assign req           = i_disp_rsrc_cnt[gi*CNT_W +: CNT_W];
            assign credit_ok[gi] = (credit >= req);

            scariv_credit_counter #(
                .MAX (CREDIT_MAX),
                .W   (CNT_W)
            ) u_credit (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_consume (fire ? req : '0),
                .i_return  ((ret_en && i_ret_valid[gi]) ? i_ret_cnt[gi*CNT_W +: CNT_W] : '0),
                .i_reload  (reload),
                .o_cnt     (credit),
                .o_err     (credit_err[gi])
            );

            assign o_credit[gi*CNT_W +: CNT_W] = credit;
        end
    endgenerate

    // Branch-tag pool: same counter with a one-tag consume/return granularity.
    scariv_credit_counter #(
        .MAX (BRTAG_MAX),
        .W   (BRTAG_W)
    ) u_brtag (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_consume (BRTAG_W'(fire && i_disp_is_br_included)),
        .i_return  (BRTAG_W'(ret_en && i_brtag_ret)),
        .i_reload  (reload),
        .o_cnt     (brtag_cnt),
        .o_err     (brtag_err)
    );

    assign brtag_ok = !i_disp_is_br_included || (brtag_cnt != '0);

    // Ready looks only at registered credits, so a same-cycle return can never
    // enable the dispatch it coincides with.
    assign o_disp_ready = !blocked && (&credit_ok) && brtag_ok;
    assign fire         = i_disp_valid && o_disp_ready;

    // Every cause bit is a term of ready, so the vector is zero whenever
    // ready is high.
    assign o_stall_cause = {blocked, !brtag_ok, ~credit_ok};
    assign o_credit_err  = (|credit_err) || brtag_err;

`ifdef SCARIV_DISP_CREDIT_PERF_EN
    // ------------------------------------------------------------------
    // Stall-cycle counters, one per cause bit, saturating at all-ones
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_RSRC + 2; gi++) begin : g_perf
            logic [31:0] stall_cyc_reg;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    stall_cyc_reg <= '0;
                end else if (i_disp_valid && o_stall_cause[gi] && (stall_cyc_reg != '1)) begin
                    stall_cyc_reg <= stall_cyc_reg + 32'd1;
                end
            end

            assign o_stall_cycles[gi*32 +: 32] = stall_cyc_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_scariv_disp_credit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scariv_disp_credit_ctrl
//   Directed-vector bench. The driver applies one vector per cycle and pushes
//   the hand-computed response into a queue; a monitor pops one entry on each
//   falling edge and compares it against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_scariv_disp_credit_ctrl;

    localparam int N  = 4;
    localparam int CW = 5;

    logic            clk;
    logic            rst_n;
    logic            disp_valid;
    logic [N*CW-1:0] disp_rsrc_cnt;
    logic            disp_br;
    logic            disp_ready;
    logic [N-1:0]    ret_valid;
    logic [N*CW-1:0] ret_cnt;
    logic            brtag_ret;
    logic            flush;
    logic [N*CW-1:0] credit;
    logic [N+1:0]    stall_cause;
    logic            credit_err;
`ifdef SCARIV_DISP_CREDIT_PERF_EN
    logic [(N+2)*32-1:0] stall_cycles;
`endif

    scariv_disp_credit_ctrl dut (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_disp_valid          (disp_valid),
        .i_disp_rsrc_cnt       (disp_rsrc_cnt),
        .i_disp_is_br_included (disp_br),
        .o_disp_ready          (disp_ready),
        .i_ret_valid           (ret_valid),
        .i_ret_cnt             (ret_cnt),
        .i_brtag_ret           (brtag_ret),
        .i_flush               (flush),
        .o_credit              (credit),
        .o_stall_cause         (stall_cause),
        .o_credit_err          (credit_err)
`ifdef SCARIV_DISP_CREDIT_PERF_EN
        ,
        .o_stall_cycles        (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              id;
        logic            ready;
        logic [N+1:0]    stall;
        logic            chk_credit;
        logic [N*CW-1:0] credit;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn_id   = 0;

    function automatic logic [N*CW-1:0] pk(input int a, input int b, input int c, input int d);
        pk = {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    // Apply one cycle of stimulus and queue the outputs expected in that cycle.
    task automatic step(input logic v, input logic [N*CW-1:0] req, input logic br,
                        input logic [N-1:0] rv, input logic [N*CW-1:0] rc,
                        input logic brr, input logic fl,
                        input logic e_ready, input logic [N+1:0] e_stall,
                        input logic ck, input logic [N*CW-1:0] e_credit, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        disp_valid    = v;
        disp_rsrc_cnt = req;
        disp_br       = br;
        ret_valid     = rv;
        ret_cnt       = rc;
        brtag_ret     = brr;
        flush         = fl;
        e.id         = txn_id;
        e.ready      = e_ready;
        e.stall      = e_stall;
        e.chk_credit = ck;
        e.credit     = e_credit;
        e.err        = e_err;
        exp_q.push_back(e);
        txn_id++;
    endtask

    task automatic idle_inputs();
        disp_valid    = 1'b0;
        disp_rsrc_cnt = '0;
        disp_br       = 1'b0;
        ret_valid     = '0;
        ret_cnt       = '0;
        brtag_ret     = 1'b0;
        flush         = 1'b0;
    endtask

    // Monitor: compare one queued expectation per cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (disp_ready !== e.ready) begin
                n_fail++;
                $display("FAIL ready txn %0d: got %b expected %b", e.id, disp_ready, e.ready);
            end
            n_checks++;
            if (stall_cause !== e.stall) begin
                n_fail++;
                $display("FAIL stall_cause txn %0d: got %b expected %b", e.id, stall_cause, e.stall);
            end
            n_checks++;
            if (credit_err !== e.err) begin
                n_fail++;
                $display("FAIL credit_err txn %0d: got %b expected %b", e.id, credit_err, e.err);
            end
            if (e.chk_credit) begin
                n_checks++;
                if (credit !== e.credit) begin
                    n_fail++;
                    $display("FAIL credit txn %0d: got %h expected %h", e.id, credit, e.credit);
                end
            end
            $display("txn %0d: ready=%b stall=%b credit=%h err=%b", e.id, disp_ready, stall_cause, credit, credit_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [N+1:0] S_NONE  = 6'b000000;
    localparam logic [N+1:0] S_ALU   = 6'b000001;
    localparam logic [N+1:0] S_BR    = 6'b010000;
    localparam logic [N+1:0] S_BRALU = 6'b010001;
    localparam logic [N+1:0] S_FL    = 6'b100000;

    initial begin
        logic [N*CW-1:0] c16;
        logic [N*CW-1:0] cdep;
        logic [N*CW-1:0] z;
        c16  = pk(16, 16, 16, 16);
        cdep = pk(0, 13, 16, 16);
        z    = '0;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state and first dispatch
        step(0, z,               0, 4'b0000, z,               0, 0, 1, S_NONE, 1, c16, 0);
        step(1, pk(4,2,1,0),     0, 4'b0000, z,               0, 0, 1, S_NONE, 1, c16, 0);
        step(1, pk(9,0,0,0),     0, 4'b0000, z,               0, 0, 1, S_NONE, 1, pk(12,14,15,16), 0);
        // ALU short (3 < 4); same-cycle return of 1 must not enable it
        step(1, pk(4,0,0,0),     0, 4'b0001, pk(1,0,0,0),     0, 0, 0, S_ALU,  1, pk(3,14,15,16), 0);
        step(1, pk(4,0,0,0),     0, 4'b0000, z,               0, 0, 1, S_NONE, 1, pk(4,14,15,16), 0);
        step(1, pk(0,4,0,0),     0, 4'b0000, z,               0, 0, 1, S_NONE, 1, pk(0,14,15,16), 0);
        // LSU dispatch 2 with same-cycle return 5 at credit 10
        step(1, pk(0,2,0,0),     0, 4'b0010, pk(0,5,0,0),     0, 0, 1, S_NONE, 1, pk(0,10,15,16), 0);
        step(0, z,               0, 4'b0100, pk(0,0,1,0),     0, 0, 1, S_NONE, 1, pk(0,13,15,16), 0);
        // BRU already full: over-return clamps and sets sticky error
        step(0, z,               0, 4'b0100, pk(0,0,1,0),     0, 0, 1, S_NONE, 1, pk(0,13,16,16), 0);
        step(0, z,               0, 4'b0000, z,               0, 0, 1, S_NONE, 1, cdep, 1);
        // Consume all eight branch tags
        for (int i = 0; i < 8; i++)
            step(1, z,           1, 4'b0000, z,               0, 0, 1, S_NONE, 1, cdep, 1);
        step(1, z,               1, 4'b0000, z,               1, 0, 0, S_BR,   1, cdep, 1);
        step(1, z,               1, 4'b0000, z,               0, 0, 1, S_NONE, 1, cdep, 1);
        step(1, pk(1,0,0,0),     1, 4'b0000, z,               0, 0, 0, S_BRALU,1, cdep, 1);
        // Flush: flush cycle + 3 drain cycles blocked, return during drain ignored
        step(1, z,               0, 4'b0000, z,               0, 1, 0, S_FL,   1, cdep, 1);
        step(0, z,               0, 4'b0001, pk(5,0,0,0),     0, 0, 0, S_FL,   1, cdep, 1);
        step(0, z,               0, 4'b0000, z,               0, 0, 0, S_FL,   1, cdep, 1);
        step(0, z,               0, 4'b0000, z,               0, 0, 0, S_FL,   1, cdep, 1);
        // Reloaded: full credits and branch tags available, error still held
        step(1, c16,             1, 4'b0000, z,               0, 0, 1, S_NONE, 1, c16, 1);
        // Flush again, re-flush at drain count 1 extends the drain
        step(0, z,               0, 4'b0000, z,               0, 1, 0, S_FL,   1, z, 1);
        step(0, z,               0, 4'b0000, z,               0, 0, 0, S_FL,   1, z, 1);
        step(0, z,               0, 4'b0000, z,               0, 1, 0, S_FL,   1, z, 1);
        step(0, z,               0, 4'b0000, z,               0, 0, 0, S_FL,   1, z, 1);
        step(0, z,               0, 4'b0000, z,               0, 0, 0, S_FL,   1, z, 1);
        step(0, z,               0, 4'b0000, z,               0, 0, 0, S_FL,   1, z, 1);
        step(0, z,               0, 4'b0000, z,               0, 0, 1, S_NONE, 1, c16, 1);
        step(1, pk(1,1,1,1),     0, 4'b0000, z,               0, 0, 1, S_NONE, 1, c16, 1);

        // Asynchronous reset mid-run clears credits and the sticky error
        @(negedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        step(0, z,               0, 4'b0000, z,               0, 0, 1, S_NONE, 1, c16, 0);
        step(0, z,               0, 4'b0000, z,               0, 0, 1, S_NONE, 1, c16, 0);

        @(posedge clk);
        #1;
        idle_inputs();
        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scariv_disp_credit_ctrl.md
Name: scariv_disp_credit_ctrl

Overview:
Credit-based dispatch scheduler between the rename/dispatch stage and the scheduler/issue queues. Holds one free-entry credit counter per resource class plus a branch-tag pool. Drives dispatch ready only when every class in the dispatch group's resource count, and a branch tag if one is needed, fit. Handles pipeline flush with a fixed drain period, then reloads all credits.

Parameters:
NUM_RSRC, 4, number of resource classes (ALU, LSU, BRU, CSU order from package enum)
CREDIT_MAX, 16, entries per class issue queue
BRTAG_MAX, 8, branch tags available
CNT_W, $clog2(CREDIT_MAX+1), credit/request counter width
FLUSH_LAT, 3, drain cycles after flush before credits reload (>=1)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_disp_valid  in  1  dispatch group valid
i_disp_rsrc_cnt  in  NUM_RSRC*CNT_W  requested entries per class, class k at [k*CNT_W +: CNT_W]
i_disp_is_br_included  in  1  group needs one branch tag
o_disp_ready  out  1  dispatch accepted when valid&ready
i_ret_valid  in  NUM_RSRC  per-class credit return strobe
i_ret_cnt  in  NUM_RSRC*CNT_W  entries freed per class this cycle
i_brtag_ret  in  1  one branch tag freed
i_flush  in  1  commit-stage pipeline flush
o_credit  out  NUM_RSRC*CNT_W  current free credits per class
o_stall_cause  out  NUM_RSRC+2  bit k = class k short, bit NUM_RSRC = brtag short, bit NUM_RSRC+1 = flushing
o_credit_err  out  1  sticky over-return / underflow error

Behaviour:
- Reset (async, i_reset_n=0): credits=CREDIT_MAX, brtag=BRTAG_MAX, state RUN, drain counter 0, o_credit_err=0. Consequent outputs: o_disp_ready=1, o_stall_cause=0.
- States: RUN, DRAIN.
  - RUN -> DRAIN on i_flush.
  - DRAIN counts FLUSH_LAT-1 down to 0. At 0 it returns to RUN with all credits reloaded to max.
  - i_flush in DRAIN restarts the counter.
- o_disp_ready is combinational. It is high iff all of: state==RUN, !i_flush, credit[k] >= req[k] for every k, and (!is_br_included | brtag>0). Ready is independent of i_disp_valid.
- fire = i_disp_valid & o_disp_ready.
- Registered update, visible the next cycle: credit[k] <= credit[k] - (fire ? req[k] : 0) + (ret_valid[k] ? ret_cnt[k] : 0). Compute in CNT_W+1 bits.
- Same-cycle dispatch and return on one class are both applied. A return never enables the same-cycle dispatch; ready uses the registered credit.
- Result > CREDIT_MAX: clamp to CREDIT_MAX and set o_credit_err. The bit stays set until reset.
- Brtag uses the same rule with width $clog2(BRTAG_MAX+1) and clamp BRTAG_MAX.
- Returns during DRAIN are ignored, because of the reload.
- o_stall_cause is combinational, and is zero when ready.

Optional Feature:
SCARIV_DISP_CREDIT_PERF_EN: adds output o_stall_cycles (NUM_RSRC+2 counters, 32 bits each, saturating). A counter increments each cycle that i_disp_valid=1 and its stall_cause bit=1. Counters reset to 0. Without the macro the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- scariv_pkg: rsrc_class_t enum, resource_cnt_t (packed array of CNT_W fields), brtag count type, disp_credit_state_t.
- One sub-module, scariv_credit_counter: one saturating credit counter with consume/return/reload/err. It is instantiated NUM_RSRC times plus once for brtag.

Test Plan:
- Reset, then valid with req={4,2,1,0}, no br -> ready=1. Next cycle o_credit={12,14,15,16}.
- ALU credit=3, req ALU=4 -> ready=0, stall_cause=0b000001. Return ALU 1 in that cycle -> ready=1 next cycle.
- Dispatch req LSU=2 with same-cycle LSU return 5 at credit 10 -> next cycle credit 13, err=0.
- BRU credit=16, return 1 -> credit stays 16, o_credit_err=1 and held.
- Brtag=0, group with br -> ready=0, stall bit4. brtag_ret -> next cycle ready=1, brtag=1.
- Credits depleted, i_flush one cycle -> ready=0 for FLUSH_LAT+1 cycles including the flush cycle, stall bit5. Then all credits=16, brtag=8, ready=1. A flush at drain count 1 extends by FLUSH_LAT.
